// File: rtl/cpu7_ifu_fetch.sv
// Instruction fetch: sequential PC generation, in-order icache requests,
// a small fetch queue feeding decode, and redirect flush with stale-response discard.
module cpu7_ifu_fetch #(
  parameter int GRLEN = 32,
  parameter logic [GRLEN-1:0] RESET_PC = GRLEN'(32'h1c000000),
  parameter int FQ_DEPTH = 4,
  parameter int HINT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ifu_icu_req,
  output logic [GRLEN-1:0]  ifu_icu_addr,
  input  logic              icu_ifu_ack,
  input  logic              icu_ifu_rvalid,
  input  logic [31:0]       icu_ifu_rdata,
  input  logic              exu_ifu_stall,
  input  logic              exu_ifu_redirect,
  input  logic [GRLEN-1:0]  exu_ifu_redirect_pc,
  output logic              fdp_dec_valid,
  output logic [GRLEN-1:0]  fdp_dec_pc,
  output logic [31:0]       fdp_dec_inst,
  output logic [GRLEN-3:0]  fdp_dec_br_target,
  output logic              fdp_dec_br_taken,
  output logic              fdp_dec_exception,
  output logic [5:0]        fdp_dec_exccode,
  output logic [HINT_W-1:0] fdp_dec_hint
);

  localparam int AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] S_RST  = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]       state;
  logic [GRLEN-1:0] fetch_pc;
  logic [GRLEN-1:0] resp_pc;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    discard;
  logic [CW-1:0]    count;
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;

  logic [GRLEN-1:0] q_pc   [FQ_DEPTH];
  logic [31:0]      q_inst [FQ_DEPTH];
  logic             q_exc  [FQ_DEPTH];

  logic             run;
  logic             aligned;
  logic             empty;
  logic             full;
  logic [CW:0]      occ;
  logic             credit;
  logic             issue;
  logic             rsp_push;
  logic             exc_push;
  logic             push;
  logic             pop;
  logic [GRLEN-1:0] push_pc;
  logic [31:0]      push_inst;
  logic [CW-1:0]    inflight_next;

  assign run     = (state == S_RUN);
  assign aligned = (fetch_pc[1:0] == 2'b00);
  assign empty   = (count == '0);
  assign full    = (count == CW'(FQ_DEPTH));
  // Credit covers queued plus in-flight, so a push can never hit a full queue.
  assign occ     = {1'b0, inflight} + {1'b0, count};
  assign credit  = (occ < (CW+1)'(FQ_DEPTH));

  assign ifu_icu_req  = run & aligned & credit & ~exu_ifu_redirect;
  assign ifu_icu_addr = fetch_pc;
  assign issue        = ifu_icu_req & icu_ifu_ack;

  assign rsp_push = icu_ifu_rvalid & (discard == '0)
                  & ~exu_ifu_redirect;
  assign exc_push = run & ~aligned & (inflight == '0) & ~full
                  & ~icu_ifu_rvalid & ~exu_ifu_redirect;
  assign push     = rsp_push | exc_push;
  assign push_pc  = rsp_push ? resp_pc : fetch_pc;
  assign push_inst = rsp_push ? icu_ifu_rdata : 32'h0;

  assign inflight_next = inflight + CW'(issue) - CW'(icu_ifu_rvalid);

  assign fdp_dec_valid = ~empty & ~exu_ifu_stall & ~exu_ifu_redirect;
  assign pop           = fdp_dec_valid;

  assign fdp_dec_pc        = q_pc[head];
  assign fdp_dec_inst      = q_inst[head];
  assign fdp_dec_exception = q_exc[head];
  assign fdp_dec_exccode   = q_exc[head] ? 6'h08 : 6'h00;
  assign fdp_dec_br_target = q_pc[head][GRLEN-1:2] + (GRLEN-2)'(1);
  assign fdp_dec_br_taken  = 1'b0;
  assign fdp_dec_hint      = '0;

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]   <= push_pc;
      q_inst[tail] <= push_inst;
      q_exc[tail]  <= exc_push;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RST;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (exu_ifu_redirect) begin
      // Everything still outstanding after this cycle is stale.
      state    <= S_RUN;
      fetch_pc <= exu_ifu_redirect_pc;
      resp_pc  <= exu_ifu_redirect_pc;
      inflight <= inflight_next;
      discard  <= inflight_next;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= inflight_next;
      count    <= count + CW'(push) - CW'(pop);
      if (issue)
        fetch_pc <= fetch_pc + GRLEN'(4);
      if (icu_ifu_rvalid && discard != '0)
        discard <= discard - CW'(1);
      if (rsp_push)
        resp_pc <= resp_pc + GRLEN'(4);
      if (push)
        tail <= tail + AW'(1);
      if (pop)
        head <= head + AW'(1);
      unique case (1'b1)
        (state == S_RST): state <= S_RUN;
        (state == S_RUN): if (exc_push) state <= S_HALT;
        default: state <= state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(icu_ifu_rvalid && inflight == '0));
  end

endmodule

// File: tb/tb_cpu7_ifu_fetch.sv
// Scoreboard bench for cpu7_ifu_fetch with a behavioural in-order icache.
// Expected entries are queued at ack/redirect time and popped on decode output.
module tb_cpu7_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_icu_req;
  logic [31:0] ifu_icu_addr;
  logic        icu_ifu_ack = 1'b0;
  logic        icu_ifu_rvalid = 1'b0;
  logic [31:0] icu_ifu_rdata = '0;
  logic        exu_ifu_stall = 1'b0;
  logic        exu_ifu_redirect = 1'b0;
  logic [31:0] exu_ifu_redirect_pc = '0;
  logic        fdp_dec_valid;
  logic [31:0] fdp_dec_pc;
  logic [31:0] fdp_dec_inst;
  logic [29:0] fdp_dec_br_target;
  logic        fdp_dec_br_taken;
  logic        fdp_dec_exception;
  logic [5:0]  fdp_dec_exccode;
  logic [4:0]  fdp_dec_hint;

  cpu7_ifu_fetch dut (
    .clk                 (clk),
    .rst                 (rst),
    .ifu_icu_req         (ifu_icu_req),
    .ifu_icu_addr        (ifu_icu_addr),
    .icu_ifu_ack         (icu_ifu_ack),
    .icu_ifu_rvalid      (icu_ifu_rvalid),
    .icu_ifu_rdata       (icu_ifu_rdata),
    .exu_ifu_stall       (exu_ifu_stall),
    .exu_ifu_redirect    (exu_ifu_redirect),
    .exu_ifu_redirect_pc (exu_ifu_redirect_pc),
    .fdp_dec_valid       (fdp_dec_valid),
    .fdp_dec_pc          (fdp_dec_pc),
    .fdp_dec_inst        (fdp_dec_inst),
    .fdp_dec_br_target   (fdp_dec_br_target),
    .fdp_dec_br_taken    (fdp_dec_br_taken),
    .fdp_dec_exception   (fdp_dec_exception),
    .fdp_dec_exccode     (fdp_dec_exccode),
    .fdp_dec_hint        (fdp_dec_hint)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } rsp_t;

  exp_t expq[$];
  rsp_t pend[$];

  int checks = 0;
  int errors = 0;

  int          ack_pct = 100;
  int          rv_pct = 100;
  int          dmin = 1;
  int          dmax = 1;
  logic        rst_v = 1'b1;
  logic        stall_v = 1'b0;
  logic        redir_v = 1'b0;
  logic [31:0] redir_pc_v = '0;

  int          cyc = 0;
  logic [31:0] next_pc = 32'h1c000000;
  bit          want_first = 0;
  logic [31:0] first_pc = '0;
  int          nacks = 0;
  int          nout = 0;
  int          nreq = 0;
  logic        last_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    exp_t        e;
    rsp_t        r;
    logic        ack_l;
    logic [31:0] nx;
    @(negedge clk);
    rst = rst_v;
    exu_ifu_stall = stall_v;
    exu_ifu_redirect = redir_v;
    exu_ifu_redirect_pc = redir_pc_v;
    icu_ifu_rvalid = 1'b0;
    icu_ifu_rdata = $urandom;
    if (!rst_v && pend.size() > 0 && pend[0].rdy <= cyc
        && $urandom_range(99) < rv_pct) begin
      r = pend.pop_front();
      icu_ifu_rvalid = 1'b1;
      icu_ifu_rdata = r.addr ^ 32'hA5A5A5A5;
    end
    #1;
    ack_l = ifu_icu_req && ($urandom_range(99) < ack_pct);
    icu_ifu_ack = ack_l;
    #1;
    last_valid = fdp_dec_valid;
    if (ifu_icu_req) nreq++;
    if (rst_v) begin
      pend.delete();
      expq.delete();
      next_pc = 32'h1c000000;
      want_first = 0;
    end else begin
      if (redir_v) begin
        check("redir_req", ifu_icu_req, 0);
        check("redir_valid", fdp_dec_valid, 0);
        expq.delete();
        next_pc = redir_pc_v;
        want_first = 1;
        first_pc = redir_pc_v;
        if (redir_pc_v[1:0] != 2'b00)
          expq.push_back(exp_t'{redir_pc_v, 32'h0, 1'b1});
      end
      if (ack_l) begin
        nacks++;
        check("addr", ifu_icu_addr, next_pc);
        r.addr = ifu_icu_addr;
        r.rdy = cyc + $urandom_range(dmax, dmin);
        pend.push_back(r);
        expq.push_back(exp_t'{next_pc, next_pc ^ 32'hA5A5A5A5, 1'b0});
        next_pc = next_pc + 32'd4;
      end
      if (fdp_dec_valid) begin
        nout++;
        if (expq.size() == 0) begin
          check("unexp_out", 1, 0);
        end else begin
          e = expq.pop_front();
          nx = e.pc + 32'd4;
          check("pc", fdp_dec_pc, e.pc);
          check("inst", fdp_dec_inst, e.inst);
          check("exc", fdp_dec_exception, e.exc);
          check("exccode", fdp_dec_exccode, e.exc ? 6'h08 : 6'h00);
          check("br_target", fdp_dec_br_target, nx[31:2]);
          check("taken_hint", {fdp_dec_br_taken, fdp_dec_hint}, 0);
        end
        if (want_first) begin
          check("first_pc", fdp_dec_pc, first_pc);
          want_first = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redir_v = 1'b1;
    redir_pc_v = pc;
    step();
    redir_v = 1'b0;
  endtask

  initial begin
    int first_valid;
    int nv;

    rst_v = 1'b1;
    repeat (3) begin
      step();
      check("rst_req", ifu_icu_req, 0);
      check("rst_valid", fdp_dec_valid, 0);
    end

    rst_v = 1'b0;
    cyc = 0;
    first_valid = -1;
    nv = 0;
    repeat (20) begin
      step();
      if (last_valid) begin
        nv++;
        if (first_valid < 0) first_valid = cyc - 1;
      end
    end
    check("first_valid_cyc", first_valid, 3);
    check("stream_count", nv, 17);

    stall_v = 1'b1;
    nv = 0;
    repeat (10) begin
      step();
      if (last_valid) nv++;
    end
    check("stall_valid", nv, 0);
    check("full_req", ifu_icu_req, 0);
    stall_v = 1'b0;
    repeat (4) begin
      step();
      check("release_valid", last_valid, 1);
    end

    ack_pct = 0;
    for (int i = 0; i < 50 && (pend.size() + expq.size()) > 0; i++)
      step();
    check("idle", pend.size() + expq.size(), 0);
    rv_pct = 0;
    ack_pct = 100;
    nacks = 0;
    for (int i = 0; i < 10 && nacks < 2; i++)
      step();
    ack_pct = 0;
    check("inflight2", pend.size(), 2);
    redirect_to(32'h1c000100);
    rv_pct = 100;
    ack_pct = 100;
    for (int i = 0; i < 20 && want_first; i++)
      step();
    check("redir2_seen", want_first, 0);
    repeat (8) step();

    redirect_to(32'h1c000300);
    for (int i = 0; i < 20 && want_first; i++)
      step();
    check("coinc_seen", want_first, 0);
    repeat (6) step();

    redirect_to(32'hfffffff8);
    repeat (10) step();
    check("wrap_seen", want_first, 0);

    redirect_to(32'h1c000102);
    nreq = 0;
    nout = 0;
    repeat (15) step();
    check("mis_req", nreq, 0);
    check("mis_out", nout, 1);
    redirect_to(32'h1c000200);
    repeat (10) step();
    check("resume_seen", want_first, 0);

    ack_pct = 70;
    rv_pct = 70;
    dmin = 1;
    dmax = 4;
    nout = 0;
    for (int i = 0; i < 30000 && nout < 1000; i++) begin
      stall_v = ($urandom_range(3) == 0);
      redir_v = ($urandom_range(59) == 0);
      redir_pc_v = 32'h1c000000 | ($urandom & 32'h0000fffc);
      if ($urandom_range(9) == 0) redir_pc_v[1] = 1'b1;
      step();
    end
    redir_v = 1'b0;
    stall_v = 1'b0;
    check("rand_done", nout >= 1000, 1);

    ack_pct = 0;
    rv_pct = 100;
    for (int i = 0; i < 200 && (pend.size() + expq.size()) > 0; i++)
      step();
    check("drain", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu7_ifu_fetch.md
Name: cpu7_ifu_fetch

Overview:
- Fetch-side producer of the fdp_dec_* interface. Drives the decode stage's per-instruction input register, which loads whenever fdp_dec_valid is high and has no back-pressure of its own.
- Generates sequential PCs and issues in-order requests to the instruction cache. Buffers returned instructions in a small fetch queue, and presents one instruction per cycle unless the execute stage stalls.
- Handles redirects from branch resolution and exceptions by flushing the queue and discarding stale in-flight responses. Static not-taken prediction.

Parameters:
- GRLEN, 32, address/PC width.
- RESET_PC, 32'h1c000000, first fetch address after reset.
- FQ_DEPTH, 4, fetch queue entries. Also the maximum of queued plus in-flight requests. Power of 2, at least 2.
- HINT_W, 5, width of fdp_dec_hint.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ifu_icu_req  out  1  cache request valid.
- ifu_icu_addr  out  GRLEN  request address, word aligned.
- icu_ifu_ack  in  1  request accepted this cycle.
- icu_ifu_rvalid  in  1  response valid. Responses return in order, at least 1 cycle after ack.
- icu_ifu_rdata  in  32  instruction word.
- exu_ifu_stall  in  1  decode must not load this cycle.
- exu_ifu_redirect  in  1  redirect fetch (branch mispredict or exception/eret).
- exu_ifu_redirect_pc  in  GRLEN  new fetch PC.
- fdp_dec_valid  out  1  instruction presented, consumed this cycle.
- fdp_dec_pc  out  GRLEN  instruction PC.
- fdp_dec_inst  out  32  instruction.
- fdp_dec_br_target  out  GRLEN-2  predicted next PC[GRLEN-1:2], i.e. (pc+4)>>2.
- fdp_dec_br_taken  out  1  constant 0.
- fdp_dec_exception  out  1  fetch exception on this entry.
- fdp_dec_exccode  out  6  6'h08 (ADEF) when exception, else 0.
- fdp_dec_hint  out  HINT_W  constant 0.

Behaviour:
- Reset values:
  - req=0, fdp_dec_valid=0.
  - Queue empty; inflight=0; discard=0.
  - fetch_pc=resp_pc=RESET_PC; state S_RST.
- FSM:
  - S_RST: one cycle after rst deasserts, then go to S_RUN.
  - S_RUN: issue requests.
  - S_HALT: no requests; waiting for redirect.
- Request issue (S_RUN):
  - ifu_icu_req=1 when fetch_pc[1:0]==0 and inflight+count < FQ_DEPTH.
  - ifu_icu_addr=fetch_pc, held stable until ack.
  - On req&ack: fetch_pc += 4 (wraps modulo 2^GRLEN) and inflight++.
- Misaligned fetch_pc (S_RUN):
  - No request is issued.
  - When inflight==0 and queue not full, enqueue {pc=fetch_pc, inst=0, exception=1, exccode=6'h08}, then go to S_HALT.
- Response handling:
  - On rvalid, inflight-- always.
  - If discard>0: discard-- and drop the data.
  - Else: enqueue {resp_pc, rdata, exc=0} and resp_pc += 4.
  - rvalid when inflight==0 is illegal; flag with a simulation assertion.
- Output (combinational from queue head):
  - fdp_dec_valid = !empty & !exu_ifu_stall & !exu_ifu_redirect.
  - The head pops when fdp_dec_valid=1.
  - All fdp_dec_* data fields reflect the head entry; they are don't-care when not valid.
- Queue:
  - Circular buffer with wrap-around pointers and a count of 0..FQ_DEPTH.
  - Push and pop in the same cycle leave count unchanged. Push while full cannot occur, because the issue credit prevents it.
- Redirect (highest priority, evaluated in the cycle exu_ifu_redirect=1):
  - Queue flushed and fdp_dec_valid forced to 0.
  - fetch_pc=resp_pc=exu_ifu_redirect_pc; state goes to S_RUN.
  - discard = inflight_next, where inflight_next = inflight + (req&ack) - rvalid. Any response arriving in the redirect cycle is dropped.
  - ifu_icu_req is forced to 0 in the redirect cycle. Requests resume the next cycle and may overlap with discarding.
- Simultaneous events:
  - Redirect + stall: redirect behaviour applies.
  - Push + pop on an empty queue: the new entry is not bypassed and becomes visible the next cycle.
  - Redirect while in S_HALT: leave S_HALT.
- Reset mid-operation:
  - All state returns to reset values.
  - Responses to requests accepted before reset are the cache's responsibility: the cache must also be reset.

Test Plan:
- Reset then stream:
  - Stimulus: ack every cycle, rvalid 1 cycle after ack, rdata=pc^32'hA5A5A5A5.
  - Required: first request addr 1c000000. fdp_dec_valid first rises 3 cycles after reset release. PCs 1c000000, 1c000004, ... back-to-back, with br_target = pc+4 >> 2.
- Stall and fill:
  - Stimulus: stall held 10 cycles.
  - Required: valid=0 throughout; req drops once inflight+count=4. On release, 4 consecutive valid cycles in PC order with no gaps or duplicates.
- Redirect with 2 in flight:
  - Stimulus: redirect to 1c000100 while inflight=2.
  - Required: the next 2 responses are dropped. The first valid output has pc=1c000100 and the inst returned for address 1c000100.
- Redirect coincident with rvalid and with ack:
  - Required: the coincident response is dropped; the acked request is counted in discard. No stale PC ever appears.
- Misaligned redirect:
  - Stimulus: redirect to 1c000102.
  - Required: no request issued. One entry presented with pc=1c000102, exception=1, exccode=08. Then no further output until the next redirect to 1c000200, which resumes normal fetch.
- Queue wrap:
  - Stimulus: random stall/ack/rvalid delays for 1000 instructions.
  - Required: the output PC sequence is strictly +4 between redirects and every inst matches the scoreboard.
